// File: rtl/unified_mem_ctrl.sv
// unified_mem_ctrl: word-organised backing store behind a fixed-latency
// load/store controller. One access is in flight at a time; loads return
// sign/zero-extended bytes and halfwords, stores update only addressed lanes.
module unified_mem_ctrl #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  func3,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);
  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic          we_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [2:0]    func3_q;
  logic [31:0]   rdata_q;
  logic          ready_q;
  logic          err_q;
  logic          busy_q;
  logic [31:0]   mem_q [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic [31:0]   word_rd;
  logic [7:0]    byte_rd;
  logic [15:0]   half_rd;
  logic          err_d;
  logic [31:0]   rdata_d;
  logic [3:0]    lane_en;
  logic [31:0]   wdata_rep;
  logic [31:0]   mem_wdata_d;
  logic          access_now;
  logic          mem_we;
  logic          unused_addr_hi;

  // Address bits above the word index are ignored so accesses wrap.
  assign unused_addr_hi = ^addr[31:AW+2];
  assign idx            = addr_q[AW+1:2];
  assign word_rd        = mem_q[idx];
  assign access_now     = (state_q == WAIT) && (cnt_q == 4'd0);
  assign mem_we         = access_now && we_q && !err_d;

  // Legality: known func3, natural alignment, no unsigned-size stores.
  always_comb begin
    err_d = 1'b1;
    case (func3_q)
      3'b000, 3'b100: err_d = 1'b0;
      3'b001, 3'b101: err_d = addr_q[0];
      3'b010:         err_d = (addr_q[1:0] != 2'b00);
      default:        err_d = 1'b1;
    endcase
    if (we_q && func3_q[2]) err_d = 1'b1;
  end

  // Load path: pick the addressed lane and extend; stores/errors return zero.
  always_comb begin
    byte_rd = word_rd[7:0];
    case (addr_q[1:0])
      2'd0: byte_rd = word_rd[7:0];
      2'd1: byte_rd = word_rd[15:8];
      2'd2: byte_rd = word_rd[23:16];
      2'd3: byte_rd = word_rd[31:24];
      default: byte_rd = word_rd[7:0];
    endcase
    half_rd = addr_q[1] ? word_rd[31:16] : word_rd[15:0];
    case (func3_q)
      3'b000:  rdata_d = {{24{byte_rd[7]}}, byte_rd};
      3'b100:  rdata_d = {24'd0, byte_rd};
      3'b001:  rdata_d = {{16{half_rd[15]}}, half_rd};
      3'b101:  rdata_d = {16'd0, half_rd};
      default: rdata_d = word_rd;
    endcase
    if (we_q || err_d) rdata_d = '0;
  end

  // Store path: replicate store data across lanes, enable only addressed ones.
  always_comb begin
    lane_en     = 4'b1111;
    wdata_rep   = wdata_q;
    mem_wdata_d = word_rd;
    case (func3_q[1:0])
      2'b00: begin
        lane_en   = 4'b0001 << addr_q[1:0];
        wdata_rep = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        lane_en   = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata_q[15:0]}};
      end
      default: lane_en = 4'b1111;
    endcase
    for (int i = 0; i < 4; i++) begin
      if (lane_en[i]) mem_wdata_d[8*i +: 8] = wdata_rep[8*i +: 8];
    end
  end

  // Backing storage; deliberately not reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= mem_wdata_d;
  end

  // Control FSM: accept in IDLE, count down in WAIT, one-cycle DONE strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      func3_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            we_q    <= we;
            addr_q  <= addr[AW+1:0];
            wdata_q <= wdata;
            func3_q <= func3;
            cnt_q   <= CNT_LOAD;
            busy_q  <= 1'b1;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            rdata_q <= rdata_d;
            err_q   <= err_d;
            ready_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign err   = err_q;
  assign busy  = busy_q;

endmodule

// File: doc/unified_mem_ctrl.md
UNIFIED_MEM_CTRL -- requirements
Module: unified_mem_ctrl

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit words of backing storage; power of two.
REQ-002 Parameter LATENCY, default 2, access latency in cycles; legal range 1..15.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req  input  1  processor requests an access; sampled only in IDLE.
REQ-006 we  input  1  1 = store, 0 = load; sampled with req.
REQ-007 addr  input  32  byte address; sampled with req.
REQ-008 wdata  input  32  store data, right-aligned; sampled with req.
REQ-009 func3  input  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-010 rdata  output  32  load result, sign/zero-extended; registered.
REQ-011 ready  output  1  one-cycle completion strobe.
REQ-012 err  output  1  completion had illegal func3 or misaligned address; valid with ready.
REQ-013 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-014 FSM states SHALL be IDLE, WAIT, DONE; busy = (state != IDLE).
REQ-015 IDLE with req=1 at a rising edge (the accept edge) SHALL latch we, addr, wdata, func3, load cnt = LATENCY-1, and go to WAIT; req=0 SHALL stay in IDLE.
REQ-016 WAIT with cnt != 0 SHALL decrement cnt and remain in WAIT.
REQ-017 WAIT with cnt == 0 SHALL perform the access on that edge and go to DONE.
REQ-018 DONE SHALL last exactly one cycle with ready=1, then return to IDLE; ready SHALL be 0 in all other states.
REQ-019 Timing: counting the accept edge as edge 0, ready SHALL be high exactly between edge LATENCY and edge LATENCY+1.
REQ-020 req asserted while busy=1 SHALL be ignored; it is not queued.
REQ-021 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored, so accesses wrap.
REQ-022 Alignment rules: halfword requires addr[0]=0; word requires addr[1:0]=00.
REQ-023 Misalignment or func3 not in {000,001,010,100,101} SHALL complete normally with err=1 and rdata=0, and SHALL NOT modify memory.
REQ-024 Stores with func3 100 or 101 SHALL be treated as illegal.
REQ-025 Loads SHALL select the byte or halfword by addr[1:0]/addr[1]; b/h SHALL sign-extend and bu/hu SHALL zero-extend.
REQ-026 Stores SHALL write only the addressed byte lanes, taking the low 8 or 16 bits of wdata; other lanes SHALL be unchanged.
REQ-027 A store completion SHALL set rdata=0.
REQ-028 rdata and err SHALL hold their last completion values until the next completion.
REQ-029 A load issued after a store to the same word SHALL observe the stored data.

Reset
REQ-030 rst=1 SHALL immediately force state=IDLE, cnt=0, ready=0, err=0, busy=0, rdata=0, independent of clk.
REQ-031 Reset during WAIT SHALL abort the access; a pending store SHALL NOT be committed.
REQ-032 Memory contents SHALL NOT be cleared by reset.
REQ-033 After rst is released, the first rising edge with req=1 SHALL be accepted.

Verification
REQ-034 LATENCY=2: sw addr=0x10, wdata=0xDEADBEEF, then lw addr=0x10 -> each ready pulses 1 cycle, 2 edges after accept; lw rdata=0xDEADBEEF, err=0.
REQ-035 Sign extension, word 0x10 = 0xDEADBEEF: lb 0x13 -> 0xFFFFFFDE; lbu 0x13 -> 0x000000DE; lh 0x10 -> 0xFFFFBEEF; lhu 0x12 -> 0x0000DEAD.
REQ-036 Byte lanes: sb addr=0x11, wdata=0x000000AA onto 0xDEADBEEF -> lw 0x10 returns 0xDEADAAEF.
REQ-037 Errors: lw addr=0x12 -> ready=1, err=1, rdata=0; sh addr=0x11 -> err=1, word unchanged; func3=011 -> err=1.
REQ-038 Busy/wrap: req held high across an access -> exactly one completion per IDLE visit, busy=1 in between; with DEPTH_WORDS=1024, sw 0x1000 then lw 0x0 -> same data.
REQ-039 Reset abort: sw 0x20, wdata=0x12345678, rst pulsed during WAIT -> ready never pulses, outputs 0 immediately; subsequent lw 0x20 returns the prior value.
